// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between pipeline writeback (port A, priority)
// and a buffered long-latency port B. Also exports a per-register pending-write scoreboard.
module regfile_wb_arbiter #(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       a_valid,
    output logic                       a_ready,
    input  logic [4:0]                 a_addr,
    input  logic [WIDTH-1:0]           a_data,
    input  logic                       b_valid,
    output logic                       b_ready,
    input  logic [4:0]                 b_addr,
    input  logic [WIDTH-1:0]           b_data,
    output logic                       rf_enwrite,
    output logic [4:0]                 rf_writereg,
    output logic [WIDTH-1:0]           rf_writedata,
    output logic [31:0]                busy,
    output logic [$clog2(DEPTH):0]     fifo_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]       fifo_addr [DEPTH];
    logic [WIDTH-1:0] fifo_data [DEPTH];
    logic [DEPTH-1:0] fifo_vld;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic [WW-1:0]    wait_cnt;

    logic starved;
    logic empty;
    logic grant_a;
    logic grant_head;
    logic enq;

    assign starved    = (wait_cnt == WW'(STARVE_LIMIT));
    assign empty      = (count == '0);
    assign a_ready    = !starved;
    assign b_ready    = (count < CW'(DEPTH));
    assign grant_a    = a_valid && !starved;
    assign grant_head = !empty && (starved || !a_valid);
    // Register-0 writes from B complete the handshake but never occupy a slot.
    assign enq        = b_valid && b_ready && (b_addr != 5'd0);
    assign fifo_count = count;

    // NOTE: the payload array is deliberately not reset; fifo_vld alone says which slots mean anything.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_addr[wr_ptr] <= b_addr;
            fifo_data[wr_ptr] <= b_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_vld <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            wait_cnt <= '0;
        end else begin
            // Enqueue and dequeue never target the same slot: that would need the FIFO both empty and full.
            if (enq) begin
                fifo_vld[wr_ptr] <= 1'b1;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (grant_head) begin
                fifo_vld[rd_ptr] <= 1'b0;
                rd_ptr           <= rd_ptr + PW'(1);
            end
            case ({enq, grant_head})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (grant_head || empty)
                wait_cnt <= '0;
            else if (!starved)
                wait_cnt <= wait_cnt + WW'(1);
        end
    end

    // Address/data only move on a real write, so the register-file inputs stay quiet otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_enwrite   <= 1'b0;
            rf_writereg  <= '0;
            rf_writedata <= '0;
        end else if (grant_a) begin
            rf_enwrite <= (a_addr != 5'd0);
            if (a_addr != 5'd0) begin
                rf_writereg  <= a_addr;
                rf_writedata <= a_data;
            end
        end else if (grant_head) begin
            rf_enwrite   <= 1'b1;
            rf_writereg  <= fifo_addr[rd_ptr];
            rf_writedata <= fifo_data[rd_ptr];
        end else begin
            rf_enwrite <= 1'b0;
        end
    end

    // NOTE: every variable driven in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_vld[i])
                busy[fifo_addr[i]] = 1'b1;
        end
    end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter and scheduler for the 32x32 register file. It shares the register file's single write port between the in-order pipeline writeback (port A, priority) and a long-latency unit such as load/mul/div (port B, buffered in a small FIFO). It drives the register file's `enwrite`/`writereg`/`writedata` inputs from registers. It also exports a per-register pending scoreboard so the decode stage can interlock on queued writes.

## Interface
- `WIDTH`, 32, data width of register-file writes
- `DEPTH`, 4, port-B FIFO entries; power of two, ≥2
- `STARVE_LIMIT`, 8, cycles the FIFO head may wait before port A is throttled; ≥1
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `a_valid`  in  1  pipeline writeback request
- `a_ready`  out  1  port A accepted this cycle; upstream holds A stable while low
- `a_addr`  in  5  destination register
- `a_data`  in  WIDTH  write data
- `b_valid`  in  1  long-latency unit request
- `b_ready`  out  1  FIFO can accept; transfer when `b_valid && b_ready`
- `b_addr`  in  5  destination register
- `b_data`  in  WIDTH  write data
- `rf_enwrite`  out  1  to register file `enwrite`
- `rf_writereg`  out  5  to register file `writereg`
- `rf_writedata`  out  WIDTH  to register file `writedata`
- `busy`  out  32  bit r set while any FIFO entry targets register r
- `fifo_count`  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Reset: FIFO empty, wait counter 0. Outputs: `rf_enwrite`=0, `rf_writereg`=0, `rf_writedata`=0, `busy`=0, `fifo_count`=0, `b_ready`=1, `a_ready`=1.
- Writes to register 0 are discarded:
  - Port A with `a_addr`=0 is accepted but produces no write.
  - Port B with `b_addr`=0 completes the handshake but is not enqueued.
- Grant, evaluated each cycle:
  - If starved (wait counter == STARVE_LIMIT), grant the FIFO head. `a_ready`=0.
  - Otherwise, if A is valid, grant A. `a_ready`=1.
  - Otherwise, if the FIFO is non-empty, grant the FIFO head.
  - Otherwise, no grant.
- `a_ready` = !(wait counter == STARVE_LIMIT), derived only from the registered counter.
- Wait counter:
  - Cleared when the head is granted or the FIFO is empty.
  - Otherwise incremented each cycle the FIFO is non-empty; saturates at STARVE_LIMIT.
- `b_ready` = (`fifo_count` < DEPTH), from registered occupancy only. No same-cycle credit from a dequeue.
- Enqueue and dequeue in the same cycle: occupancy unchanged, both take effect, valid at any occupancy below full.
- FIFO pointers wrap modulo DEPTH. Entries leave in arrival order; there is no reordering between B entries.
- `busy` is combinational: the OR of decoded addresses of all valid FIFO entries. Duplicate addresses keep the bit set until the last matching entry leaves.
- No A/B ordering guarantee for the same register. The decode stage uses `busy` to avoid WAW/RAW against queued B writes.
- A `rst` assertion during operation flushes the FIFO. Any queued B writes are lost, and the next-cycle `rf_enwrite`=0.

## Timing
- Port A: grant at cycle t → `rf_enwrite`/`rf_writereg`/`rf_writedata` valid during t+1 and written at the t+1 edge.
- Port B: handshake at cycle t → entry visible at t+1. Earliest grant is t+1, earliest `rf_enwrite` is t+2. There is no bypass path.
- `busy` bit sets at t+1 after the handshake and clears in the cycle after the head is granted.
- Worst-case B head wait = STARVE_LIMIT cycles, then 1 throttle cycle. Back-to-back starved grants are possible only if A stays valid.
- `rf_enwrite`=0 in every cycle after a no-grant cycle or a register-0 grant.

## Test plan
- Reset then A-only: `a_valid`=1, addr 5, data 0x1234 at t → `rf_enwrite`=1, reg 5, 0x1234 at t+1; `a_ready` always 1.
- B-only, A idle: B writes addr 7 = 0xAA at t → `busy[7]`=1 at t+1; write at t+2; `busy[7]`=0 at t+2.
- Fill/full: 4 B transfers with A continuously valid → `fifo_count`=4, `b_ready`=0. A fifth `b_valid` is held off. `fifo_count` stays 4.
- Starvation: FIFO holds addr 3 and A continuously valid → after 8 waiting cycles `a_ready`=0 for 1 cycle, head reg 3 is written, then `a_ready`=1. A's held request is written next.
- Register 0: A addr 0 and B addr 0 → `rf_enwrite` never 1, `busy`=0, `fifo_count` stays 0, B handshake completes.
- Simultaneous enqueue/dequeue at `fifo_count`=3 with A idle → count stays 3. Also assert `rst` with 2 entries queued → next cycle `fifo_count`=0, `busy`=0, `rf_enwrite`=0.
